// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 serial transmitter with a configurable stop-bit count and a
//            one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_start_uart,
  input  logic [7:0] i_uart_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int                 c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         c_LAST_DATA = 3'd7;
  localparam logic [2:0]         c_LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]         r_idx, w_idx_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic               r_fin;
  logic               w_fin;
  logic               w_tx;
  logic               w_bit_end;

  assign w_bit_end = (r_cnt == c_CNT_MAX);

  // Sequencer; r_idx counts data bits in DATA and stop bits in STOP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_fin       = 1'b0;
    w_tx        = 1'b1;
    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (i_start_uart) begin
          w_shift_nxt = i_uart_data;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_bit_end) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_tx = r_shift[r_idx];
        if (w_bit_end) begin
          if (r_idx == c_LAST_DATA) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_STOP: begin
        w_tx = 1'b1;
        if (w_bit_end) begin
          if (r_idx == c_LAST_STOP) begin
            w_idx_nxt   = '0;
            w_fin       = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_fin   <= w_fin;
    end
  end

  // Outputs trail the sequencer by one edge so every port is a flop.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_tx   <= 1'b1;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_tx   <= w_tx;
      o_busy <= (r_state != S_IDLE);
      o_done <= r_fin;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Directed, table-driven bench for uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       st, st2;
  logic [7:0] d, d2;
  logic       tx, busy, done;
  logic       tx2, busy2, done2;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut (
    .clk          (clk),
    .i_reset      (rst),
    .i_start_uart (st),
    .i_uart_data  (d),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_done       (done)
  );

  uart_tx #(.CLKS_PER_BIT(2), .STOP_BITS(2)) u_dut2 (
    .clk          (clk),
    .i_reset      (rst),
    .i_start_uart (st2),
    .i_uart_data  (d2),
    .o_tx         (tx2),
    .o_busy       (busy2),
    .o_done       (done2)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_line;      // bit i = line level during serial bit i
    int         restart_edge;  // edge where a second strobe is sampled, 0 = none
    logic [7:0] restart_data;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    d  = v.data;
    st = 1'b1;
    tick();
    st = 1'b0;
    d  = ~v.data;
    chk("accept_tx", tx, 1'b1);
    chk("accept_busy", busy, 1'b0);
    for (int k = 1; k <= 45; k++) begin
      if (k == v.restart_edge) begin
        st = 1'b1;
        d  = v.restart_data;
      end
      tick();
      st = 1'b0;
      if (k <= 40) chk("frame_tx", tx, v.exp_line[(k-1)/4]);
      else         chk("idle_tx", tx, 1'b1);
      chk("frame_busy", busy, (k <= 40));
      chk("frame_done", done, (k == 41));
    end
  endtask

  initial begin
    logic [9:0] a5_line;
    logic       exp_tx2;
    int         rel;

    vecs[0] = '{8'h50, 10'b1010100000, 0,  8'h00};
    vecs[1] = '{8'h50, 10'b1010100000, 10, 8'hFF};
    vecs[2] = '{8'hA5, 10'b1101001010, 0,  8'h00};
    vecs[3] = '{8'h3C, 10'b1001111000, 0,  8'h00};
    vecs[4] = '{8'hFF, 10'b1111111110, 0,  8'h00};
    a5_line = 10'b1101001010;

    rst = 1'b0; st = 1'b0; st2 = 1'b0; d = 8'h00; d2 = 8'h00;
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tx2", tx2, 1'b1);
    repeat (5) tick();
    chk("rst_hold_tx", tx, 1'b1);
    chk("rst_hold_busy", busy, 1'b0);
    chk("rst_hold_done", done, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Held-high start: second frame accepted on the same edge as o_done.
    d  = 8'hA5;
    st = 1'b1;
    tick();
    for (int k = 1; k <= 84; k++) begin
      tick();
      if (k == 41) st = 1'b0;
      rel = (k <= 40) ? k : k - 41;
      if (k == 41 || k >= 82) chk("held_tx", tx, 1'b1);
      else                    chk("held_tx", tx, a5_line[(rel-1)/4]);
      chk("held_busy", busy, (k <= 40) || (k >= 42 && k <= 81));
      chk("held_done", done, (k == 41) || (k == 82));
    end

    // Reset asserted between clock edges during data bit 3.
    d  = 8'h3C;
    st = 1'b1;
    tick();
    st = 1'b0;
    repeat (18) tick();
    chk("pre_abort_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("post_abort_done", done, 1'b0);
      chk("post_abort_tx", tx, 1'b1);
    end
    run_frame('{8'h00, 10'b1000000000, 0, 8'h00});

    // Two stop bits, two clocks per bit, byte 8'h01.
    d2  = 8'h01;
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    chk("s2_accept_busy", busy2, 1'b0);
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k <= 2)       exp_tx2 = 1'b0;
      else if (k <= 4)  exp_tx2 = 1'b1;
      else if (k <= 18) exp_tx2 = 1'b0;
      else              exp_tx2 = 1'b1;
      chk("s2_tx", tx2, exp_tx2);
      chk("s2_busy", busy2, (k <= 22));
      chk("s2_done", done2, (k == 23));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
